// File: rtl/mem_dump_reader.sv
// mem_dump_reader: a rising edge of done_in starts a stream of data-memory words start_addr..end_addr
// (wrapping mod 2^AW) over a valid/ready port. Define DUMP_CHECKSUM_EN to append a DW-bit sum beat.
module mem_dump_reader #(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          done_in,
    input  logic [AW-1:0] start_addr,
    input  logic [AW-1:0] end_addr,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd_en,
    input  logic [DW-1:0] mem_dat,
    output logic [DW-1:0] out_data,
    output logic [AW-1:0] out_addr,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_last,
    output logic          busy,
    output logic          finished
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        CAPT,
        SEND,
        CSUM,
        FIN
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] cur_q, cur_d;
    logic [AW-1:0] last_q, last_d;
    logic [AW-1:0] out_addr_q, out_addr_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic          out_valid_q, out_valid_d;
    logic          out_last_q, out_last_d;
    logic          done_prev_q, done_prev_d;
    logic          armed_q, armed_d;
    logic          trigger;
    logic          at_last;

`ifdef DUMP_CHECKSUM_EN
    logic [DW-1:0] sum_q, sum_d;
`endif

    // armed_q blocks a trigger until done_in has been seen low after reset, so a level
    // still high at reset release is not mistaken for a fresh rising edge.
    assign trigger = done_in && !done_prev_q && armed_q;
    assign at_last = (cur_q == last_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cur_q       <= '0;
            last_q      <= '0;
            out_addr_q  <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            done_prev_q <= 1'b0;
            armed_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            last_q      <= last_d;
            out_addr_q  <= out_addr_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            done_prev_q <= done_prev_d;
            armed_q     <= armed_d;
        end
    end

`ifdef DUMP_CHECKSUM_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end
`endif

    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        last_d      = last_q;
        out_addr_d  = out_addr_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        done_prev_d = done_in;
        armed_d     = armed_q || !done_in;
`ifdef DUMP_CHECKSUM_EN
        sum_d       = sum_q;
`endif

        case (state_q)
            IDLE: begin
                if (trigger) begin
                    cur_d   = start_addr;
                    last_d  = end_addr;
`ifdef DUMP_CHECKSUM_EN
                    sum_d   = '0;
`endif
                    state_d = READ;
                end
            end

            READ: begin
                state_d = CAPT;
            end

            CAPT: begin
                out_data_d  = mem_dat;
                out_addr_d  = cur_q;
                out_valid_d = 1'b1;
`ifdef DUMP_CHECKSUM_EN
                out_last_d  = 1'b0;
`else
                out_last_d  = at_last;
`endif
                state_d     = SEND;
            end

            SEND: begin
                if (out_ready) begin
`ifdef DUMP_CHECKSUM_EN
                    sum_d = sum_q + out_data_q;
`endif
                    if (!at_last) begin
                        cur_d       = cur_q + AW'(1);
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        state_d     = READ;
                    end else begin
`ifdef DUMP_CHECKSUM_EN
                        // The sum beat follows directly; out_valid stays high across the switch.
                        out_data_d  = sum_d;
                        out_addr_d  = last_q;
                        out_last_d  = 1'b1;
                        state_d     = CSUM;
`else
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        state_d     = FIN;
`endif
                    end
                end
            end

`ifdef DUMP_CHECKSUM_EN
            CSUM: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    state_d     = FIN;
                end
            end
`endif

            FIN: begin
                if (!done_in) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign mem_addr  = cur_q;
    assign mem_rd_en = (state_q == READ);
    assign out_data  = out_data_q;
    assign out_addr  = out_addr_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign busy      = (state_q == READ) || (state_q == CAPT) || (state_q == SEND) ||
                       (state_q == CSUM);
    assign finished  = (state_q == FIN);

endmodule

// File: tb/tb_mem_dump_reader.sv
// Bench for mem_dump_reader: table-driven dumps, stall/reset/retrigger sequences and random dumps,
// all checked against a queue of expected beats built from the bench's own memory image.
module tb_mem_dump_reader;

    localparam int AW = 8;
    localparam int DW = 8;
`ifdef DUMP_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          done_in = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic [AW-1:0] end_addr = '0;
    logic [AW-1:0] mem_addr;
    logic          mem_rd_en;
    logic [DW-1:0] mem_dat = '0;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_addr;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic          out_last;
    logic          busy;
    logic          finished;

    always #5 clk = ~clk;

    mem_dump_reader #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset), .done_in(done_in),
        .start_addr(start_addr), .end_addr(end_addr),
        .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_dat(mem_dat),
        .out_data(out_data), .out_addr(out_addr), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last),
        .busy(busy), .finished(finished)
    );

    logic [7:0] mem [256];
    always @(posedge clk) if (mem_rd_en) mem_dat <= mem[mem_addr];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0] data;
        logic [7:0] addr;
        logic       last;
        bit         csum;
    } beat_t;
    beat_t expq[$];

    int cyc = 0;
    always @(posedge clk) cyc++;

    int   ready_mode = 0;
    logic ready_man = 1'b1;
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = ready_man;
        endcase
    end

    // Monitor: beats are sampled on the falling edge, where valid&ready means accepted next rise.
    int         acc_cnt = 0, rd_cnt = 0, last_acc_cyc = 0, prev_data_cyc = 0;
    bit         first_beat = 1'b1;
    logic       pv_valid = 1'b0, pv_ready = 1'b0, pv_last = 1'b0;
    logic [7:0] pv_data = '0, pv_addr = '0;

    always @(negedge clk) begin
        beat_t b;
        if (reset) begin
            pv_valid = 1'b0;
        end else begin
            if (mem_rd_en) begin
                rd_cnt++;
                chk("rd_en_while_valid", out_valid, 0);
            end
            if (pv_valid && !pv_ready) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", out_data, pv_data);
                chk("hold_addr", out_addr, pv_addr);
                chk("hold_last", out_last, pv_last);
            end
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got addr %0h data %0h, required no beat", out_addr, out_data);
                end else begin
                    b = expq.pop_front();
                    chk("beat_data", out_data, b.data);
                    chk("beat_addr", out_addr, b.addr);
                    chk("beat_last", out_last, b.last);
                    if (!b.csum) begin
                        if (ready_mode == 0 && !first_beat) chk("beat_spacing", cyc - prev_data_cyc, 3);
                        prev_data_cyc = cyc;
                        first_beat = 1'b0;
                    end
                end
                acc_cnt++;
                last_acc_cyc = cyc;
            end
            pv_valid = out_valid;
            pv_ready = out_ready;
            pv_data  = out_data;
            pv_addr  = out_addr;
            pv_last  = out_last;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference model: the dump is simply the words at (s+i) mod 256 for i in 0..n-1.
    task automatic start_dump(input logic [7:0] s, input logic [7:0] e, output int n);
        beat_t b;
        logic [7:0] a;
        logic [7:0] sum;
        n = ((int'(e) - int'(s) + 256) % 256) + 1;
        sum = '0;
        expq.delete();
        for (int i = 0; i < n; i++) begin
            a = 8'((int'(s) + i) % 256);
            b.data = mem[a];
            b.addr = a;
            b.last = (CS == 0) && (i == n - 1);
            b.csum = 1'b0;
            sum = sum + mem[a];
            expq.push_back(b);
        end
        if (CS != 0) begin
            b.data = sum;
            b.addr = e;
            b.last = 1'b1;
            b.csum = 1'b1;
            expq.push_back(b);
        end
        rd_cnt = 0;
        acc_cnt = 0;
        first_beat = 1'b1;
        start_addr = s;
        end_addr = e;
        done_in = 1'b0;
        tick(2);
        done_in = 1'b1;
        tick(1);
        start_addr = 8'($urandom);
        end_addr = 8'($urandom);
    endtask

    task automatic finish_dump(input int words);
        int k;
        k = 0;
        @(negedge clk);
        while (!finished && k < words * 8 + 40) begin
            @(negedge clk);
            k++;
        end
        chk("finished_seen", finished, 1);
        chk("fin_latency", cyc - last_acc_cyc, 1);
        chk("busy_in_fin", busy, 0);
        chk("beat_count", acc_cnt, words + CS);
        chk("read_count", rd_cnt, words);
        chk("beats_missing", expq.size(), 0);
        tick(3);
        chk("finished_held", finished, 1);
        done_in = 1'b0;
        tick(2);
        chk("finished_cleared", finished, 0);
        chk("busy_after_fin", busy, 0);
        expq.delete();
    endtask

    task automatic run_dump(input logic [7:0] s, input logic [7:0] e, input int words);
        int n;
        start_dump(s, e, n);
        finish_dump(words);
    endtask

    task automatic wait_beat(input logic [7:0] a, input string name);
        int k;
        k = 0;
        @(negedge clk);
        while (!(out_valid && out_addr == a) && k < 60) begin
            @(negedge clk);
            k++;
        end
        chk(name, out_addr, a);
    endtask

    typedef struct {
        logic [7:0] s;
        logic [7:0] e;
        int         words;
    } vec_t;

    initial begin
        vec_t tbl[5];
        int n;
        logic [7:0] d0, a0, rs, rl;
        int rd0;

        tbl[0] = '{8'h10, 8'h13, 4};
        tbl[1] = '{8'hFE, 8'h01, 4};
        tbl[2] = '{8'h40, 8'h41, 2};
        tbl[3] = '{8'h55, 8'h55, 1};
        tbl[4] = '{8'h80, 8'h7F, 256};

        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[8'h10] = 8'h11; mem[8'h11] = 8'h22; mem[8'h12] = 8'h33; mem[8'h13] = 8'h44;
        mem[8'h40] = 8'h80; mem[8'h41] = 8'h90;

        tick(2);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_addr", out_addr, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_rd_en", mem_rd_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_finished", finished, 0);
        reset = 1'b0;
        tick(2);

        ready_mode = 0;
        for (int i = 0; i < 5; i++) run_dump(tbl[i].s, tbl[i].e, tbl[i].words);

        // Back-pressure: hold beat 2 for several cycles.
        ready_mode = 2;
        ready_man = 1'b1;
        start_dump(8'h30, 8'h35, n);
        wait_beat(8'h30, "stall_beat1_seen");
        ready_man = 1'b0;
        wait_beat(8'h31, "stall_beat2_seen");
        rd0 = rd_cnt; d0 = out_data; a0 = out_addr;
        repeat (5) begin
            @(negedge clk);
            chk("stall_valid", out_valid, 1);
            chk("stall_data", out_data, d0);
            chk("stall_addr", out_addr, a0);
        end
        chk("stall_no_read", rd_cnt, rd0);
        ready_man = 1'b1;
        finish_dump(n);

        // Reset during SEND of beat 3 of 8 with done_in held high.
        start_dump(8'h20, 8'h27, n);
        wait_beat(8'h21, "rst_beat2_seen");
        ready_man = 1'b0;
        wait_beat(8'h22, "rst_beat3_seen");
        #2 reset = 1'b1;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_data", out_data, 0);
        chk("midrst_out_addr", out_addr, 0);
        chk("midrst_mem_addr", mem_addr, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_out_last", out_last, 0);
        tick(2);
        reset = 1'b0;
        expq.delete();
        acc_cnt = 0;
        rd_cnt = 0;
        ready_man = 1'b1;
        tick(30);
        chk("postrst_no_beats", acc_cnt, 0);
        chk("postrst_no_reads", rd_cnt, 0);
        chk("postrst_busy", busy, 0);
        run_dump(8'h20, 8'h27, 8);

        // done_in toggling mid-dump must not abort or retrigger; a later edge gives an identical dump.
        ready_mode = 0;
        start_dump(8'h60, 8'h65, n);
        tick(4);
        done_in = 1'b0;
        tick(3);
        done_in = 1'b1;
        finish_dump(n);
        run_dump(8'h60, 8'h65, 6);

        for (int i = 0; i < 10; i++) begin
            rs = 8'($urandom);
            rl = 8'($urandom_range(1, 12));
            ready_mode = int'($urandom_range(0, 1));
            start_dump(rs, rs + rl - 8'd1, n);
            finish_dump(int'(rl));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/mem_dump_reader.md
MEM_DUMP_READER -- requirements
Module: mem_dump_reader

Interface
REQ-001 Parameter AW, default 8, data-memory address width.
REQ-002 Parameter DW, default 8, data-memory word width.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 done_in  input  1  core program-complete flag; level.
REQ-006 start_addr  input  AW  first address to dump; sampled at trigger.
REQ-007 end_addr  input  AW  last address to dump, inclusive; sampled at trigger.
REQ-008 mem_addr  output  AW  data-memory read address.
REQ-009 mem_rd_en  output  1  read strobe; memory returns mem_dat one cycle later.
REQ-010 mem_dat  input  DW  data-memory read data.
REQ-011 out_data  output  DW  dumped word.
REQ-012 out_addr  output  AW  address of out_data.
REQ-013 out_valid  output  1  out_data/out_addr/out_last valid.
REQ-014 out_ready  input  1  sink accepts current beat.
REQ-015 out_last  output  1  final beat of the dump.
REQ-016 busy  output  1  dump in progress.
REQ-017 finished  output  1  dump complete; held until done_in falls.

Function
REQ-018 States SHALL be IDLE, READ, CAPT, SEND, FIN; IDLE after reset.
REQ-019 Trigger SHALL be a rising edge of done_in detected in IDLE (registered previous value); latch start_addr into cur and end_addr into last; go READ.
REQ-020 READ: mem_rd_en=1, mem_addr=cur for exactly one cycle; go CAPT.
REQ-021 CAPT: register mem_dat into out_data, cur into out_addr; set out_valid; out_last=1 iff cur==last (and checksum disabled); go SEND.
REQ-022 SEND: out_valid, out_data, out_addr, out_last SHALL stay stable until a cycle with out_ready=1.
REQ-023 On accept with cur!=last: cur SHALL increment modulo 2^AW (255 wraps to 0), out_valid drops, go READ.
REQ-024 On accept with cur==last: go FIN (or checksum beat, REQ-035).
REQ-025 start_addr > end_addr SHALL wrap: dump start..2^AW-1 then 0..end; start==end dumps one word; full range (end=start-1) dumps 2^AW words.
REQ-026 FIN: finished=1, busy=0; return to IDLE when done_in=0; a fresh rising edge is required for another dump.
REQ-027 busy SHALL be 1 in READ, CAPT, SEND (and checksum beat).
REQ-028 done_in edges or level changes while busy SHALL be ignored; done_in falling mid-dump SHALL NOT abort.
REQ-029 mem_rd_en SHALL be 0 outside READ; mem_addr SHALL hold cur at all times.
REQ-030 Peak throughput: one beat per 3 cycles with out_ready tied high.
REQ-031 out_ready while out_valid=0 SHALL have no effect.

Reset
REQ-032 reset=1 SHALL immediately force IDLE; mem_rd_en, out_valid, out_last, busy, finished = 0; out_data, out_addr, mem_addr, cur, last, edge register = 0.
REQ-033 Reset mid-dump SHALL abandon the dump without further memory reads; if done_in=1 at release, no dump starts until done_in falls and rises again.

Configuration
REQ-034 Macro DUMP_CHECKSUM_EN selects a trailing checksum beat.
REQ-035 With DUMP_CHECKSUM_EN: running DW-bit sum (mod 2^DW) of all accepted data words, cleared at trigger; after last data beat accepted, emit one extra beat out_data=sum, out_addr=last, out_last=1, same handshake, then FIN; data beats have out_last=0.
REQ-036 Without DUMP_CHECKSUM_EN: no sum logic; out_last on final data beat; dump ends after it.

Verification
REQ-037 mem[0x10..0x13]=11,22,33,44; start=0x10,end=0x13; done_in rises; out_ready=1 -> beats 11,22,33,44 at addr 0x10..0x13, 3 cycles apart, out_last on 44, finished next cycle.
REQ-038 start=0xFE,end=0x01 -> addresses FE,FF,00,01 in order; 4 beats.
REQ-039 out_ready low 5 cycles on beat 2 -> out_data/out_addr stable all 5 cycles, no extra mem_rd_en, no drop/duplicate.
REQ-040 reset pulse during SEND of beat 3 of 8 with done_in held 1 -> outputs zero immediately; no beats after release until done_in toggles 0->1.
REQ-041 done_in toggled 1->0->1 during dump -> single dump only; after finished, done_in 0 then 1 -> second identical dump.
REQ-042 DUMP_CHECKSUM_EN, data 0x80,0x90 -> beats 80,90 (out_last=0) then 0x10 with out_last=1; without macro -> out_last on 90, no third beat.
